// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// video_timing_gen: free-running raster counters with registered sync, active-draw and
// frame-start strobes. Define VIDEO_TIMING_GEN_FRAME_COUNT_EN to build the frame counter.
module video_timing_gen #(
  parameter int ACTIVE_H = 1280,
  parameter int H_FRONT  = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BACK   = 220,
  parameter int ACTIVE_V = 720,
  parameter int V_FRONT  = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 20,
  parameter int FC_WIDTH = 6
) (
  input  logic                clk_in,
  input  logic                rst_in,
  output logic [10:0]         hcount_out,
  output logic [9:0]          vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                ad_out,
  output logic                new_frame_out,
  output logic [FC_WIDTH-1:0] frame_count_out
);

  localparam int TOTAL_H  = ACTIVE_H + H_FRONT + H_SYNC + H_BACK;
  localparam int TOTAL_V  = ACTIVE_V + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = ACTIVE_H + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = ACTIVE_V + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [10:0] H_LAST = 11'(TOTAL_H - 1);
  localparam logic [9:0]  V_LAST = 10'(TOTAL_V - 1);

  generate
    if (TOTAL_H > 2048 || TOTAL_V > 1024 || TOTAL_H < 1 || TOTAL_V < 1) begin : g_bad_timing
      $error("video_timing_gen: TOTAL_H must be 1..2048 and TOTAL_V 1..1024");
    end
  endgenerate

  logic        r_started;
  logic [10:0] w_h_next;
  logic [9:0]  w_v_next;
  logic        w_hsync_next;
  logic        w_vsync_next;
  logic        w_ad_next;
  logic        w_new_frame_next;

  // Next position; the first edge after reset presents (0,0) rather than advancing.
  always_comb begin
    w_h_next = '0;
    w_v_next = '0;
    if (r_started) begin
      if (hcount_out == H_LAST) begin
        w_h_next = '0;
        w_v_next = (vcount_out == V_LAST) ? 10'd0 : vcount_out + 10'd1;
      end else begin
        w_h_next = hcount_out + 11'd1;
        w_v_next = vcount_out;
      end
    end
  end

  // Strobes are decoded from the next position so they register alongside the counts.
  always_comb begin
    w_hsync_next     = (int'(w_h_next) >= HS_START) && (int'(w_h_next) < HS_END);
    w_vsync_next     = (int'(w_v_next) >= VS_START) && (int'(w_v_next) < VS_END);
    w_ad_next        = (int'(w_h_next) < ACTIVE_H) && (int'(w_v_next) < ACTIVE_V);
    w_new_frame_next = (int'(w_h_next) == ACTIVE_H) && (int'(w_v_next) == ACTIVE_V);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_started     <= 1'b0;
      hcount_out    <= '0;
      vcount_out    <= '0;
      hsync_out     <= 1'b0;
      vsync_out     <= 1'b0;
      ad_out        <= 1'b0;
      new_frame_out <= 1'b0;
    end else begin
      r_started     <= 1'b1;
      hcount_out    <= w_h_next;
      vcount_out    <= w_v_next;
      hsync_out     <= w_hsync_next;
      vsync_out     <= w_vsync_next;
      ad_out        <= w_ad_next;
      new_frame_out <= w_new_frame_next;
    end
  end

`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
  logic [FC_WIDTH-1:0] r_frame_count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_frame_count <= '0;
    end else if (w_new_frame_next) begin
      r_frame_count <= r_frame_count + FC_WIDTH'(1);
    end
  end

  assign frame_count_out = r_frame_count;
`else
  assign frame_count_out = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// Bench for video_timing_gen on a reduced raster: every cycle is compared with a position
// model derived from elapsed cycles since reset release; random async resets are injected.
module tb_video_timing_gen;

  localparam int AH = 16, HF = 3, HS = 4, HB = 5;
  localparam int AV = 10, VF = 2, VS = 3, VB = 4;
  localparam int FCW = 4;
  localparam int TH = AH + HF + HS + HB;
  localparam int TV = AV + VF + VS + VB;
  localparam int FRAME = TH * TV;
  localparam int NF_OFF = AV * TH + AH;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [10:0]    hcount;
  logic [9:0]     vcount;
  logic           hsync, vsync, ad, new_frame;
  logic [FCW-1:0] frame_count;

  int     n_checks = 0;
  int     n_errors = 0;
  longint t;

  video_timing_gen #(
    .ACTIVE_H(AH), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .ACTIVE_V(AV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FC_WIDTH(FCW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .hcount_out(hcount),
    .vcount_out(vcount),
    .hsync_out(hsync),
    .vsync_out(vsync),
    .ad_out(ad),
    .new_frame_out(new_frame),
    .frame_count_out(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Reference: position is simply the elapsed-cycle index folded onto the raster.
  task automatic check_model(input longint tt);
    longint h, v, nf, fc;
    h = tt % TH;
    v = (tt / TH) % TV;
    nf = (tt >= NF_OFF) ? ((tt - NF_OFF) / FRAME) + 1 : 0;
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    fc = nf % (longint'(1) << FCW);
`else
    fc = 0;
`endif
    chk_val("hcount", 64'(hcount), 64'(h));
    chk_val("vcount", 64'(vcount), 64'(v));
    chk_val("hsync", 64'(hsync), 64'((h >= AH + HF) && (h < AH + HF + HS)));
    chk_val("vsync", 64'(vsync), 64'((v >= AV + VF) && (v < AV + VF + VS)));
    chk_val("ad", 64'(ad), 64'((h < AH) && (v < AV)));
    chk_val("new_frame", 64'(new_frame), 64'((h == AH) && (v == AV)));
    chk_val("frame_count", 64'(frame_count), 64'(fc));
  endtask

  task automatic check_zero(input string tag);
    chk_val({tag, "_all"}, {33'b0, hcount, vcount, hsync, vsync, ad, new_frame, frame_count}, 64'd0);
  endtask

  initial begin
    int n_ad, n_vs, n_nf, n_hs_line0, first_hs, len, hold;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");

    // Long run from release: covers full frames, frame counter wrap and aggregate counts.
    n_ad = 0; n_vs = 0; n_nf = 0; n_hs_line0 = 0; first_hs = -1;
    rst = 1'b0;
    t = -1;
    len = ((1 << FCW) + 2) * FRAME;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      t++;
      check_model(t);
      if (t < FRAME) begin
        n_ad += int'(ad);
        n_vs += int'(vsync);
        n_nf += int'(new_frame);
        if (t < TH) begin
          n_hs_line0 += int'(hsync);
          if (hsync && first_hs < 0) first_hs = int'(hcount);
        end
        if (t == FRAME - 1) begin
          chk_val("ad_per_frame", 64'(n_ad), 64'(AH * AV));
          chk_val("vsync_per_frame", 64'(n_vs), 64'(VS * TH));
          chk_val("new_frame_per_frame", 64'(n_nf), 64'd1);
          chk_val("hsync_per_line", 64'(n_hs_line0), 64'(HS));
          chk_val("hsync_first_h", 64'(first_hs), 64'(AH + HF));
        end
      end
    end
    $display("seg 0: %0d cycles from (0,0), ended at (%0d,%0d) fc=%0d", len, hcount, vcount, frame_count);

    // Random-length runs each ended by an asynchronous reset between clock edges.
    for (int s = 1; s <= 12; s++) begin
      len = $urandom_range(1, 2 * FRAME);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        t++;
        check_model(t);
      end
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      hold = $urandom_range(1, 3);
      repeat (hold) begin
        @(negedge clk);
        check_zero("rst_hold");
      end
      $display("seg %0d: %0d cycles, reset at (t=%0d) held %0d edges", s, len, t, hold);
      rst = 1'b0;
      t = -1;
    end

    for (int c = 0; c < FRAME + 5; c++) begin
      @(negedge clk);
      t++;
      check_model(t);
    end
    $display("seg 13: %0d cycles after final release", FRAME + 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
